uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
UART transmit controller. It accepts one parallel data word per valid/ready handshake and serialises it LSB-first onto tx_out as a frame: start bit, data bits, optional parity bit, then stop bit(s). It sequences the existing combinational parity_gen block, which computes the parity of the latched word. It sits between the host-side TX interface and the serial line, driven by the system clock with an internal baud divider.

Parameters:
- WIDTH, 8: data bits per frame.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be ≥ 2.
- PARITY_EN, 1: 1 inserts a parity bit after the data; 0 omits it.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk, input, 1: the only clock. All logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- tx_data, input, WIDTH: word to transmit; sampled only on handshake.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: controller can accept a word.
- tx_out, output, 1: serial line; idles high.
- busy, output, 1: a frame is in progress.
- tx_done, output, 1: one-cycle pulse at end of frame.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, tx_out=1, busy=0, tx_done=0, all counters 0.
- tx_ready is combinational: (state==IDLE) && !rst. It is 0 while rst is high.
- States and transitions:
  - IDLE → START when tx_valid && tx_ready at a rising edge. tx_data is latched into shift_reg on the same edge.
  - START: tx_out=0.
  - DATA: tx_out=shift_reg[0]; shift right once per bit period; runs WIDTH bits.
  - PARITY (only if PARITY_EN): tx_out=parity_gen(latched word) ^ PARITY_ODD.
  - STOP: tx_out=1 for STOP_BITS bit periods.
  - STOP → IDLE.
- Bit timing: every non-IDLE state bit lasts exactly CLKS_PER_BIT cycles.
  - bit_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 on state or bit advance.
  - bit_idx counts 0..WIDTH-1 in DATA, and 0..STOP_BITS-1 in STOP.
- Frame latency: the handshake edge is cycle 0, and tx_out falls at cycle 1.
- Frame length: F = (1 + WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- End of frame: on the edge ending the last stop bit, the state returns to IDLE and tx_done=1 for one cycle (cycle F+1). tx_ready rises in that same cycle.
- Back-to-back frames: there is at least one IDLE cycle (tx_out=1) between frames. With tx_valid held high, the next start bit begins F+1 cycles after the previous one.
- busy = (state != IDLE). It is registered with the state.
- Parity: computed from the latched copy of the word, never the live tx_data.
- While busy: changes on tx_data or tx_valid are ignored, and the frame in flight is unaffected.
- Reset mid-frame: the frame is abandoned. The next edge with rst high gives tx_out=1, busy=0, and no tx_done pulse.
- Counter widths: bit_cnt is $clog2(CLKS_PER_BIT) bits. bit_idx is max($clog2(WIDTH),1) bits. Wrap-around is explicit compare-to-max, never natural overflow.

Decomposition:
- Shared uart_pkg contains:
  - the state enum: IDLE, START, DATA, PARITY, STOP;
  - the PARITY_EVEN/PARITY_ODD constants;
  - the LINE_IDLE=1 and START_BIT=0 constants.
- One sub-module: the existing parity_gen, instantiated with WIDTH and fed from the latched word.
- No other hierarchy.

Test Plan (WIDTH=8, CLKS_PER_BIT=4 unless stated):
- Even parity, 1 stop bit, send 0xA5:
  - tx_out, sampled every 4 cycles from cycle 1, is 0,1,0,1,0,0,1,0,1,0(parity),1(stop).
  - Frame is 44 cycles, with tx_done at cycle 45.
- PARITY_ODD=1, send 0x07 (three ones): parity bit = 0. Send 0x03 (two ones): parity bit = 1.
- PARITY_EN=0, STOP_BITS=2, send 0xFF:
  - Sequence is 0 then ten 1s (8 data + 2 stop).
  - Frame is 44 cycles, with no parity slot.
- tx_valid held high while sending 0x00 then 0xFF:
  - Exactly one idle-high cycle between frames.
  - Second start bit at cycle 46.
  - tx_ready is high only in the IDLE cycles.
- Mid-frame interference and reset, sending 0x5A:
  - Toggle tx_data to 0x00 during DATA: transmitted bits are still 0x5A's.
  - Assert rst during data bit 3: tx_out=1 and busy=0 on the next edge, no tx_done.
  - tx_ready=1 in the first cycle after rst drops.
- CLKS_PER_BIT=2 boundary, send 0x80:
  - Each bit lasts exactly 2 cycles.
  - MSB=1 appears in the last data slot.
  - Even parity = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART transmit types and line-level constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

`default_nettype wire

// File: rtl/parity_gen.sv
// ============================================================================
// Module      : parity_gen
// Description : Combinational even-parity (XOR reduction) of a data word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    assign parity_o = ^data_i;

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmitter: valid/ready word in, LSB-first framed serial out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_ctrl #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             tx_done
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_SEL   = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD
                                                               : uart_pkg::PARITY_EVEN;

    tx_state_e        state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_q;
    logic             tx_out_q;
    logic             busy_q;
    logic             done_q;
    logic             w_parity;
    logic             w_parity_bit;

    // Parity always comes from the word captured at handshake, not live input.
    parity_gen #(
        .WIDTH (WIDTH)
    ) u_parity_gen (
        .data_i   (word_q),
        .parity_o (w_parity)
    );

    assign w_parity_bit = w_parity ^ PAR_SEL;

    assign tx_ready = (state_q == IDLE) && !rst;
    assign tx_out   = tx_out_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

    // tx_out is registered and loaded with the value of the upcoming bit on
    // the edge that enters it, so the line changes exactly at bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            tx_out_q  <= LINE_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (tx_valid) begin
                    shift_q   <= tx_data;
                    word_q    <= tx_data;
                    state_q   <= START;
                    tx_out_q  <= START_BIT;
                    busy_q    <= 1'b1;
                    bit_cnt_q <= '0;
                    bit_idx_q <= '0;
                end
            end else if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else begin
                bit_cnt_q <= '0;
                case (state_q)
                    START: begin
                        state_q  <= DATA;
                        tx_out_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                    DATA: begin
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q  <= PARITY;
                                tx_out_q <= w_parity_bit;
                            end else begin
                                state_q  <= STOP;
                                tx_out_q <= LINE_IDLE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            tx_out_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                    PARITY: begin
                        state_q  <= STOP;
                        tx_out_q <= LINE_IDLE;
                    end
                    STOP: begin
                        if (bit_idx_q == STOP_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                        tx_out_q <= LINE_IDLE;
                    end
                    default: begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        tx_out_q <= LINE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
